// File: rtl/spi_frame_sequencer.sv
// Frame sequencer for a time-multiplexed SPI receiver: paces chip_select frames
// and gaps, captures each channel's sample into a one-entry valid/ready buffer.
module spi_frame_sequencer #(
  parameter int FRAME_BITS  = 32,
  parameter int DATA_BITS   = 16,
  parameter int IDLE_CYCLES = 2,
  parameter int NUM_CH      = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 serial_clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 chip_select,
  input  logic [DATA_BITS-1:0] rx_data,
  output logic [DATA_BITS-1:0] sample_data,
  output logic [CH_W-1:0]      sample_ch,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int CNT_MAX = (FRAME_BITS > IDLE_CYCLES) ? FRAME_BITS : IDLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CAP_AT     = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CH_W-1:0]        ch_q;
  logic                   cs_q;
  logic                   busy_q;
  logic                   valid_q;
  logic [DATA_BITS-1:0]   data_q;
  logic [CH_W-1:0]        sch_q;
  logic                   ovr_q;

  logic cap;
  logic load;
  logic drop;
  logic xfer;

  // The receiver latched its word on the previous edge, so rx_data is stable here.
  assign cap  = (state_q == FRAME) && (cnt_q == CAP_AT);
  assign xfer = valid_q & sample_ready;
  assign load = cap & (~valid_q | sample_ready);
  assign drop = cap & valid_q & ~sample_ready;

  always_ff @(posedge serial_clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sch_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= FRAME;
            cs_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FRAME: begin
          if (cnt_q == FRAME_LAST) begin
            state_q <= GAP;
            cs_q    <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (enable) begin
              state_q <= FRAME;
              cs_q    <= 1'b0;
              ch_q    <= (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
            end else begin
              state_q <= IDLE;
              ch_q    <= '0;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          cs_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase

      if (load) begin
        valid_q <= 1'b1;
        data_q  <= rx_data;
        sch_q   <= ch_q;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end

      // A drop on the same edge as a clear request wins.
      if (drop) begin
        ovr_q <= 1'b1;
      end else if (overrun_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign chip_select  = cs_q;
  assign busy         = busy_q;
  assign sample_valid = valid_q;
  assign sample_data  = data_q;
  assign sample_ch    = sch_q;
  assign overrun      = ovr_q;

endmodule

// File: doc/spi_frame_sequencer.md
SPI_FRAME_SEQUENCER -- requirements
Module: spi_frame_sequencer

Interface
REQ-001 Parameter FRAME_BITS, default 32: serial_clk cycles per frame with chip_select low.
REQ-002 Parameter DATA_BITS, default 16: sample width; the receiver latches its sample at bit index DATA_BITS-1.
REQ-003 Parameter IDLE_CYCLES, default 2: serial_clk cycles chip_select is held high between frames; legal range is 1 or greater.
REQ-004 Parameter NUM_CH, default 2: number of time-multiplexed channels.
REQ-005 Clock: serial_clk, input, 1 bit; it is the only clock, and all logic updates on its rising edge.
REQ-006 Reset: reset, input, 1 bit; it is synchronous and active-high.
REQ-007 Port enable, input, 1 bit: requests continuous framing.
REQ-008 Port chip_select, output, 1 bit: drives the receiver; high means idle, low means frame active.
REQ-009 Port rx_data, input, DATA_BITS bits: the receiver's data_out.
REQ-010 Port sample_data, output, DATA_BITS bits: the buffered sample.
REQ-011 Port sample_ch, output, $clog2(NUM_CH) bits (minimum 1): channel index of sample_data.
REQ-012 Port sample_valid, output, 1 bit: sample_data and sample_ch are valid.
REQ-013 Port sample_ready, input, 1 bit: consumer accepts the sample.
REQ-014 Port overrun, output, 1 bit: sticky flag indicating a sample was dropped.
REQ-015 Port overrun_clr, input, 1 bit: clears overrun.
REQ-016 Port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-017 The block SHALL implement states IDLE, FRAME and GAP, with internal counter cnt and channel register ch.
REQ-018 In IDLE, chip_select SHALL be 1; when enable is 1 at an edge, the block SHALL move to FRAME and set chip_select<=0, cnt<=0, with ch unchanged.
REQ-019 In FRAME, cnt SHALL increment each edge, so that cnt=k at an edge means the receiver samples bit k on that same edge.
REQ-020 In FRAME at cnt=DATA_BITS, the block SHALL capture rx_data with tag ch into the output buffer, subject to REQ-024 to REQ-026.
REQ-021 In FRAME at cnt=FRAME_BITS-1, the block SHALL set chip_select<=1, move to GAP, and set cnt<=0.
REQ-022 In GAP, cnt SHALL increment each edge; at cnt=IDLE_CYCLES-1, the next state SHALL be chosen as follows.
- If enable is 1: move to FRAME, set chip_select<=0, cnt<=0, and ch<=(ch+1) mod NUM_CH.
- Otherwise: move to IDLE and set ch<=0.
REQ-023 As a result, chip_select SHALL be low for exactly FRAME_BITS cycles and high for exactly IDLE_CYCLES cycles, giving a period of FRAME_BITS+IDLE_CYCLES cycles.
REQ-024 Deasserting enable during FRAME or GAP SHALL NOT truncate the frame; the current frame and its gap SHALL complete.
REQ-025 The output buffer SHALL hold one entry and follow valid/ready: a transfer occurs on an edge where sample_valid=1 and sample_ready=1.
- On transfer, sample_valid clears unless a capture occurs on the same edge.
- sample_data and sample_ch SHALL hold steady while sample_valid=1 and no transfer occurs.
REQ-026 On a capture edge, the required behaviour depends on the buffer state.
- Buffer empty, or a transfer occurs on the same edge: load the new sample and set sample_valid=1.
- Otherwise: keep the old sample, discard the new one, and set overrun=1.
REQ-027 overrun SHALL clear on an edge where overrun_clr=1, unless a drop occurs on the same edge; a drop SHALL take priority.
REQ-028 The ch register SHALL wrap from NUM_CH-1 to 0.
REQ-029 sample_ch SHALL be the value of ch at the capture edge.

Reset
REQ-030 When reset is 1 at an edge, the block SHALL apply the following regardless of state, including mid-frame.
- State becomes IDLE.
- chip_select=1, cnt=0, ch=0.
- sample_valid=0, sample_data=0, sample_ch=0.
- overrun=0, busy=0.
REQ-031 Reset SHALL take priority over all other inputs.
REQ-032 After reset deasserts, the first frame SHALL start only through IDLE with enable=1.

Verification
REQ-033 Bench scenario, basic frame: with the receiver model attached and defaults, reset, then enable=1 with MOSI pattern 0xA5C3 followed by 16 zero bits.
- chip_select low for 32 cycles, then high for 2.
- sample_valid rises 1 cycle after the cnt=16 edge.
- sample_data=0xA5C3, sample_ch=0.
REQ-034 Bench scenario, channel alternation: enable held with sample_ready=1 for 4 frames of 0x1111, 0x2222, 0x3333, 0x4444.
- sample_ch sequence is 0, 1, 0, 1.
- Frame starts are spaced 34 cycles apart.
- overrun=0 throughout.
REQ-035 Bench scenario, overrun: sample_ready=0 for 2 frames.
- The first sample is held.
- overrun=1 after the second capture edge.
- overrun_clr pulse drives overrun=0.
- With overrun_clr=1 on a drop edge, overrun stays 1.
REQ-036 Bench scenario, same-edge accept: sample_ready=1 exactly on the capture edge while sample_valid=1.
- The new sample replaces the old.
- overrun stays 0.
REQ-037 Bench scenario, enable drop: enable=0 at cnt=5 of a frame.
- The frame completes all 32 low cycles plus 2 high cycles, then IDLE with busy=0.
- Next enable restarts with ch=0.
REQ-038 Bench scenario, reset mid-frame: reset=1 at cnt=10.
- On the next edge: chip_select=1, sample_valid=0, busy=0.
- A subsequent frame captures correctly.
